// File: rtl/seg7_pkg.sv
// Shared constants for the seg7 encoder/decoder pair: active-low segment patterns
// (seg[6]=a .. seg[0]=g), bus widths and the scan-decoder state encoding.
package seg7_pkg;

  localparam int AN_W  = 4;
  localparam int SEG_W = 7;
  localparam int VAL_W = 4;
  localparam int CNT_W = 4;

  localparam logic [SEG_W-1:0] DIG0  = 7'b0000001;
  localparam logic [SEG_W-1:0] DIG1  = 7'b1001111;
  localparam logic [SEG_W-1:0] DIG2  = 7'b0010010;
  localparam logic [SEG_W-1:0] DIG3  = 7'b0000110;
  localparam logic [SEG_W-1:0] DIG4  = 7'b1001100;
  localparam logic [SEG_W-1:0] DIG5  = 7'b0100100;
  localparam logic [SEG_W-1:0] DIG6  = 7'b0100000;
  localparam logic [SEG_W-1:0] DIG7  = 7'b0001111;
  localparam logic [SEG_W-1:0] DIG8  = 7'b0000000;
  localparam logic [SEG_W-1:0] DIG9  = 7'b0000100;
  localparam logic [SEG_W-1:0] BLANK = 7'b1111111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_TRACK = 2'd1,
    ST_HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/seg7_pattern_decode.sv
// Combinational inverse of the seg7 encoder table: pattern -> digit value.
// Blank reads as 4'hF without error; anything unrecognised reads 4'hF with err.
module seg7_pattern_decode
  import seg7_pkg::*;
(
  input  logic [SEG_W-1:0] pattern,
  output logic [VAL_W-1:0] value,
  output logic             err
);

  always_comb begin
    // NOTE: defaults first so every path assigns both outputs and no latch forms.
    value = 4'hF;
    err   = 1'b0;
    case (pattern)
      DIG0:    value = 4'd0;
      DIG1:    value = 4'd1;
      DIG2:    value = 4'd2;
      DIG3:    value = 4'd3;
      DIG4:    value = 4'd4;
      DIG5:    value = 4'd5;
      DIG6:    value = 4'd6;
      DIG7:    value = 4'd7;
      DIG8:    value = 4'd8;
      DIG9:    value = 4'd9;
      BLANK:   value = 4'hF;
      default: err   = 1'b1;
    endcase
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// Recovers the four displayed digits from a multiplexed active-low 7-segment scan,
// capturing each digit once per anode activation after STABLE_CYCLES stable samples.
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int STABLE_CYCLES = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  an,
  input  logic [6:0]  seg,
  output logic [15:0] digits,
  output logic [3:0]  digit_err,
  output logic        frame_valid,
  output logic        scan_err
);

  localparam logic [CNT_W-1:0] STABLE = CNT_W'(STABLE_CYCLES);

  logic [AN_W-1:0]  an_q;
  logic [SEG_W-1:0] seg_q;
  state_t           state;
  logic [AN_W-1:0]  an_trk;
  logic [1:0]       idx;
  logic [SEG_W-1:0] pat;
  logic [CNT_W-1:0] cnt;
  logic [AN_W-1:0]  captured;
  logic [VAL_W-1:0] slot_val [AN_W];
  logic [AN_W-1:0]  slot_err;

  logic [2:0]       n_low;
  logic             an_one, an_multi;
  logic             restart, advance, capture, frame_done;
  logic [1:0]       new_idx, cap_idx;
  logic [CNT_W-1:0] cnt_next;
  logic [SEG_W-1:0] trk_pat;
  logic [VAL_W-1:0] dec_val;
  logic             dec_err;

  assign n_low    = 3'($countones(~an_q));
  assign an_one   = (n_low == 3'd1);
  assign an_multi = (n_low > 3'd1);

  always_comb begin
    new_idx = 2'd0;
    for (int i = 0; i < AN_W; i++)
      if (!an_q[i]) new_idx = 2'(i);
  end

  // A new activation (or a pattern change while still tracking) restarts the count;
  // once in HOLD, samples of the same anode are ignored until the anode changes.
  assign restart  = an_one && ((state == ST_IDLE) || (an_q != an_trk) ||
                               ((state == ST_TRACK) && (seg_q != pat)));
  assign advance  = an_one && (state == ST_TRACK) && (an_q == an_trk) && (seg_q == pat);
  assign cnt_next = restart ? CNT_W'(1) :
                    (cnt >= STABLE) ? STABLE : cnt + CNT_W'(1);
  assign capture  = (restart || advance) && (cnt_next == STABLE);
  assign cap_idx  = restart ? new_idx : idx;
  assign trk_pat  = (restart || advance) ? seg_q : pat;

  assign frame_done = (captured == 4'b1111);

  seg7_pattern_decode u_decode (
    .pattern (trk_pat),
    .value   (dec_val),
    .err     (dec_err)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      an_q        <= 4'b1111;
      seg_q       <= BLANK;
      state       <= ST_IDLE;
      an_trk      <= 4'b1111;
      idx         <= 2'd0;
      pat         <= BLANK;
      cnt         <= '0;
      captured    <= '0;
      // NOTE: the shadow slots are reset explicitly so a post-reset frame never
      // exposes stale digits; this is small enough to live in flops, not RAM.
      for (int i = 0; i < AN_W; i++) slot_val[i] <= '0;
      slot_err    <= '0;
      digits      <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
      scan_err    <= 1'b0;
    end else begin
      // NOTE: non-blocking throughout, so every read below sees pre-edge values.
      an_q        <= an;
      seg_q       <= seg;
      scan_err    <= an_multi;
      frame_valid <= frame_done;

      if (frame_done) begin
        digits    <= {slot_val[3], slot_val[2], slot_val[1], slot_val[0]};
        digit_err <= slot_err;
      end

      // Clearing and a same-cycle capture are merged so the new capture survives.
      captured <= (frame_done ? 4'b0000 : captured) |
                  (capture ? (4'b0001 << cap_idx) : 4'b0000);

      if (capture) begin
        slot_val[cap_idx] <= dec_val;
        slot_err[cap_idx] <= dec_err;
      end

      if (!an_one) begin
        state <= ST_IDLE;
        cnt   <= '0;
      end else if (restart || advance) begin
        state  <= capture ? ST_HOLD : ST_TRACK;
        an_trk <= an_q;
        idx    <= cap_idx;
        pat    <= trk_pat;
        cnt    <= cnt_next;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// Bench for seg7_scan_decoder: directed scan scenarios plus random scanning, all
// checked every cycle against a sample-history model of the decoder.
module tb_seg7_scan_decoder;

  localparam int S = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  an;
  logic [6:0]  seg;
  logic [15:0] digits;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic        scan_err;

  seg7_scan_decoder #(.STABLE_CYCLES(S)) dut (
    .clk         (clk),
    .rst         (rst),
    .an          (an),
    .seg         (seg),
    .digits      (digits),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .scan_err    (scan_err)
  );

  always #5 clk = ~clk;

  localparam logic [6:0] PAT [10] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100,
    7'b0100100, 7'b0100000, 7'b0001111, 7'b0000000, 7'b0000100
  };

  int vectors    = 0;
  int miscompares = 0;
  int fv_count   = 0;
  int serr_count = 0;
  bit chk_en     = 1'b0;
  logic [15:0] last_digits = '0;
  logic [3:0]  last_derr   = '0;

  // model outputs
  logic [15:0] exp_digits;
  logic [3:0]  exp_derr;
  logic        exp_fv;
  logic        exp_serr;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s at %0t: got %0h, expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [4:0] mdecode(input logic [6:0] p);
    for (int i = 0; i < 10; i++)
      if (PAT[i] == p) return {1'b0, 4'(i)};
    if (p == 7'b1111111) return {1'b0, 4'hF};
    return {1'b1, 4'hF};
  endfunction

  // Model: a digit is captured once per activation, when the run of identical
  // registered samples of a single-low anode first reaches S. The sample taken at
  // one edge is acted on at the next; a full set of captures shows one edge later.
  initial begin
    logic [10:0] hist[$];
    logic [10:0] p;
    logic [3:0]  m_capt;
    logic [3:0]  sh_val [4];
    logic [3:0]  sh_err;
    logic [4:0]  d;
    bit          act_cap;
    int          run, lows, pidx;
    bit          cap, fd;
    act_cap = 1'b0;
    m_capt  = '0;
    sh_err  = '0;
    for (int i = 0; i < 4; i++) sh_val[i] = '0;
    exp_digits = '0; exp_derr = '0; exp_fv = 1'b0; exp_serr = 1'b0;
    forever begin
      @(posedge clk);
      if (rst) begin
        hist.delete();
        hist.push_back({4'hF, 7'h7F});
        act_cap = 1'b0;
        m_capt  = '0;
        sh_err  = '0;
        for (int i = 0; i < 4; i++) sh_val[i] = '0;
        exp_digits = '0; exp_derr = '0; exp_fv = 1'b0; exp_serr = 1'b0;
      end else begin
        p = hist[hist.size()-1];
        run = 0;
        for (int i = hist.size()-1; i >= 0; i--) begin
          if (hist[i] != p) break;
          run++;
        end
        if (hist.size() < 2 || hist[hist.size()-2][10:7] != p[10:7]) act_cap = 1'b0;
        lows = 0;
        pidx = 0;
        for (int i = 0; i < 4; i++)
          if (!p[7+i]) begin lows++; pidx = i; end
        cap = (lows == 1) && (run == S) && !act_cap;
        if (cap) act_cap = 1'b1;
        exp_serr = (lows > 1);
        fd = (m_capt == 4'hF);
        exp_fv = fd;
        if (fd) begin
          exp_digits = {sh_val[3], sh_val[2], sh_val[1], sh_val[0]};
          exp_derr   = sh_err;
          m_capt     = '0;
        end
        if (cap) begin
          d = mdecode(p[6:0]);
          m_capt[pidx] = 1'b1;
          sh_val[pidx] = d[3:0];
          sh_err[pidx] = d[4];
        end
      end
      hist.push_back({an, seg});
      if (hist.size() > 40) void'(hist.pop_front());
    end
  end

  // Compare process: every cycle, away from the sampling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (chk_en) begin
        check("digits", 32'(digits), 32'(exp_digits));
        check("digit_err", 32'(digit_err), 32'(exp_derr));
        check("frame_valid", 32'(frame_valid), 32'(exp_fv));
        check("scan_err", 32'(scan_err), 32'(exp_serr));
        if (frame_valid === 1'b1) begin
          fv_count++;
          last_digits = digits;
          last_derr   = digit_err;
        end
        if (scan_err === 1'b1) serr_count++;
      end
    end
  end

  task automatic drive(input logic [3:0] a, input logic [6:0] s, input int n);
    for (int k = 0; k < n; k++) begin
      an  = a;
      seg = s;
      @(negedge clk);
    end
  endtask

  task automatic idle(input int n);
    drive(4'b1111, 7'b1111111, n);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1;
    idle(n);
    rst = 1'b0;
  endtask

  initial begin
    int base, bserr;
    logic [3:0] ra;
    logic [6:0] rs;
    int len, kind;
    rst = 1'b1;
    an  = 4'b1111;
    seg = 7'b1111111;
    @(negedge clk);
    @(negedge clk);
    chk_en = 1'b1;
    do_reset(2);
    check("reset digits", 32'(digits), 32'h0);
    check("reset digit_err", 32'(digit_err), 32'h0);
    check("reset frame_valid", 32'(frame_valid), 32'h0);
    check("reset scan_err", 32'(scan_err), 32'h0);

    // Clean scan of 1,2,3,4
    base = fv_count;
    drive(4'b1110, PAT[1], 6);
    drive(4'b1101, PAT[2], 6);
    drive(4'b1011, PAT[3], 6);
    drive(4'b0111, PAT[4], 6);
    idle(5);
    check("scan1234 frames", fv_count - base, 1);
    check("scan1234 digits", 32'(last_digits), 32'h4321);
    check("scan1234 err", 32'(last_derr), 32'h0);

    // Illegal pattern on digit 2
    base = fv_count;
    drive(4'b1110, PAT[9], 6);
    drive(4'b1101, PAT[0], 6);
    drive(4'b1011, 7'b1111110, 6);
    drive(4'b0111, PAT[7], 6);
    idle(5);
    check("illegal frames", fv_count - base, 1);
    check("illegal digit2", 32'(last_digits[11:8]), 32'hF);
    check("illegal digits", 32'(last_digits), 32'h7F09);
    check("illegal err", 32'(last_derr), 32'b0100);

    // Digit 0 too short, then held long enough on a later pass
    base = fv_count;
    drive(4'b1110, PAT[2], 3);
    drive(4'b1101, PAT[4], 6);
    drive(4'b1011, PAT[6], 6);
    drive(4'b0111, PAT[8], 6);
    idle(5);
    check("short digit0 no frame", fv_count - base, 0);
    drive(4'b1110, PAT[2], 6);
    idle(5);
    check("digit0 retry frame", fv_count - base, 1);
    check("digit0 retry digits", 32'(last_digits), 32'h8642);

    // Two anodes low for one cycle
    bserr = serr_count;
    base  = fv_count;
    drive(4'b0011, PAT[3], 1);
    idle(4);
    check("multi anode scan_err", serr_count - bserr, 1);
    drive(4'b1101, PAT[1], 6);
    drive(4'b1011, PAT[1], 6);
    drive(4'b0111, PAT[1], 6);
    idle(5);
    check("multi anode no slot", fv_count - base, 0);

    // Reset with three digits captured, then a fresh scan
    do_reset(2);
    check("midframe reset digits", 32'(digits), 32'h0);
    base = fv_count;
    drive(4'b1110, PAT[5], 6);
    drive(4'b1101, PAT[6], 6);
    drive(4'b1011, PAT[7], 6);
    idle(4);
    check("post reset partial", fv_count - base, 0);
    drive(4'b0111, PAT[8], 6);
    idle(5);
    check("post reset frame", fv_count - base, 1);
    check("post reset digits", 32'(last_digits), 32'h8765);

    // Digit 1 toggling every other cycle, three passes
    base = fv_count;
    for (int f = 0; f < 3; f++) begin
      drive(4'b1110, PAT[1], 6);
      for (int t = 0; t < 3; t++) begin
        drive(4'b1101, PAT[3], 2);
        drive(4'b1101, PAT[4], 2);
      end
      drive(4'b1011, PAT[2], 6);
      drive(4'b0111, PAT[9], 6);
    end
    idle(5);
    check("toggle no frame", fv_count - base, 0);
    check("toggle digits held", 32'(digits), 32'h8765);

    // Random scanning
    for (int n = 0; n < 400; n++) begin
      kind = int'($urandom_range(0, 99));
      if (kind < 70) begin
        ra = 4'b1111;
        ra[$urandom_range(0, 3)] = 1'b0;
      end else if (kind < 85) begin
        ra = 4'b1111;
      end else if (kind < 98) begin
        ra = 4'($urandom_range(0, 15));
        if ($countones(~ra) < 2) ra = 4'b1010;
      end else begin
        do_reset(int'($urandom_range(1, 2)));
        continue;
      end
      kind = int'($urandom_range(0, 99));
      if (kind < 70)      rs = PAT[$urandom_range(0, 9)];
      else if (kind < 80) rs = 7'b1111111;
      else                rs = 7'($urandom_range(0, 127));
      len = int'($urandom_range(1, 8));
      drive(ra, rs, len);
    end
    idle(6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
